acc_mul_responder: RTL

Iterative integer-multiply accelerator that sits at the responder end of the accelerator bus. It accepts offloaded RISC-V M-extension multiply instructions (MUL, MULH, MULHSU, MULHU) on the request (Q) channel and computes them with a radix-2 shift-add datapath. It returns the result, tagged with the request ID, on the response (P) channel. Any other instruction, or a request addressed to a different accelerator, returns an immediate error response.

---
 rtl/acc_mul_responder_if.sv | 38 +++
 rtl/acc_mul_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/acc_mul_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | acc_mul_responder_if                                                     |
// | Accelerator bus: request (Q) and response (P) channels.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface acc_mul_responder_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ACC_ADDR_WIDTH = 5,
  parameter int ID_WIDTH       = 5
);
  logic [ACC_ADDR_WIDTH-1:0] q_addr;
  logic [31:0]               q_data_op;
  logic [DATA_WIDTH-1:0]     q_data_arga;
  logic [DATA_WIDTH-1:0]     q_data_argb;
  logic [DATA_WIDTH-1:0]     q_data_argc;
  logic [ID_WIDTH-1:0]       q_id;
  logic                      q_valid;
  logic                      q_ready;
  logic [DATA_WIDTH-1:0]     p_data;
  logic [ID_WIDTH-1:0]       p_id;
  logic                      p_error;
  logic                      p_valid;
  logic                      p_ready;

  modport master (
    output q_addr, q_data_op, q_data_arga, q_data_argb, q_data_argc, q_id, q_valid,
    output p_ready,
    input  q_ready, p_data, p_id, p_error, p_valid
  );

  modport slave (
    input  q_addr, q_data_op, q_data_arga, q_data_argb, q_data_argc, q_id, q_valid,
    input  p_ready,
    output q_ready, p_data, p_id, p_error, p_valid
  );
endinterface
`default_nettype wire

// File: rtl/acc_mul_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | acc_mul_responder                                                        |
// | Iterative radix-2 shift-add MUL/MULH/MULHSU/MULHU accelerator responder.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module acc_mul_responder #(
  parameter int                        DATA_WIDTH     = 32,
  parameter int                        ACC_ADDR_WIDTH = 5,
  parameter int                        ID_WIDTH       = 5,
  parameter logic [ACC_ADDR_WIDTH-1:0] ADDR           = '0
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  acc_mul_responder_if.slave bus
);

  localparam int c_CNT_WIDTH = $clog2(DATA_WIDTH);
  localparam int c_PROD_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_PROD_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0]   r_mplier;
  logic [c_PROD_WIDTH-1:0] r_acc;
  logic [c_CNT_WIDTH-1:0]  r_cnt;
  logic                    r_neg;
  logic [1:0]              r_funct3;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ID_WIDTH-1:0]     r_id;
  logic                    r_error;

  logic                    w_op_legal;
  logic                    w_accept_mul;
  logic [1:0]              w_funct3;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_abs_a;
  logic [DATA_WIDTH-1:0]   w_abs_b;
  logic [c_PROD_WIDTH-1:0] w_sum;
  logic [c_PROD_WIDTH-1:0] w_prod;

  // funct3[2] must be 0, so only the low two bits need to be kept.
  assign w_op_legal   = (bus.q_data_op[6:0] == 7'b0110011)
                     && (bus.q_data_op[31:25] == 7'b0000001)
                     && !bus.q_data_op[14];
  assign w_accept_mul = w_op_legal && (bus.q_addr == ADDR);
  assign w_funct3     = bus.q_data_op[13:12];

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH.
  assign w_a_neg = ((w_funct3 == 2'b01) || (w_funct3 == 2'b10)) && bus.q_data_arga[DATA_WIDTH-1];
  assign w_b_neg = (w_funct3 == 2'b01) && bus.q_data_argb[DATA_WIDTH-1];
  assign w_abs_a = w_a_neg ? ('0 - bus.q_data_arga) : bus.q_data_arga;
  assign w_abs_b = w_b_neg ? ('0 - bus.q_data_argb) : bus.q_data_argb;

  assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod = r_neg ? ('0 - w_sum) : w_sum;

  wire w_unused = ^{bus.q_data_argc, bus.q_data_op[24:15], bus.q_data_op[11:7]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus.q_ready = 1'b0;
    bus.p_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.q_ready = 1'b1;
        if (bus.q_valid) begin
          w_state_nxt = w_accept_mul ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        bus.p_valid = 1'b1;
        if (bus.p_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_funct3 <= '0;
      r_data   <= '0;
      r_id     <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.q_valid) begin
            r_id <= bus.q_id;
            if (w_accept_mul) begin
              r_funct3 <= w_funct3;
              r_mcand  <= {{DATA_WIDTH{1'b0}}, w_abs_a};
              r_mplier <= w_abs_b;
              r_neg    <= w_a_neg ^ w_b_neg;
              r_acc    <= '0;
              r_cnt    <= c_CNT_WIDTH'(DATA_WIDTH - 1);
            end else begin
              r_error <= 1'b1;
              r_data  <= '0;
            end
          end
        end
        BUSY: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - c_CNT_WIDTH'(1);
          if (r_cnt == '0) begin
            r_error <= 1'b0;
            r_data  <= (r_funct3 == 2'b00) ? w_prod[DATA_WIDTH-1:0]
                                           : w_prod[c_PROD_WIDTH-1:DATA_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.p_data  = r_data;
  assign bus.p_id    = r_id;
  assign bus.p_error = r_error;

endmodule
`default_nettype wire
